// File: rtl/conv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_pkg                                                     |
// | Description : Shared definitions for the convolution sequencer slice:      |
// |               FSM state encoding and default datapath/address widths.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_DRAIN = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam int c_PIX_DW = 9;   // pixel data width
  localparam int c_WGT_DW = 8;   // weight data width
  localparam int c_ADDR_W = 10;  // default SRAM address width
  localparam int c_OUT_DW = 20;  // accumulator / output data width

endpackage
`default_nettype wire

// File: rtl/conv_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_sequencer_if                                            |
// | Description : Bundle of the sequencer's handshake, SRAM request and MAC     |
// |               strobe signals.                                              |
// |   master : sequencer side (drives finish/busy/reqs/addrs/strobes/data)     |
// |   slave  : environment side (drives start and acc_data)                    |
// | Ports       : start, finish, busy, pixel_req/addr, weight_req/addr,        |
// |               mac_en, mac_clr, acc_data, output_req/addr/data              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface conv_sequencer_if
  import conv_pkg::*;
#(
  parameter int PIX_AW = c_ADDR_W,
  parameter int WGT_AW = c_ADDR_W,
  parameter int OUT_AW = c_ADDR_W,
  parameter int OUT_DW = c_OUT_DW
);

  logic              start;
  logic              finish;
  logic              busy;
  logic              pixel_req;
  logic [PIX_AW-1:0] pixel_addr;
  logic              weight_req;
  logic [WGT_AW-1:0] weight_addr;
  logic              mac_en;
  logic              mac_clr;
  logic [OUT_DW-1:0] acc_data;
  logic              output_req;
  logic [OUT_AW-1:0] output_addr;
  logic [OUT_DW-1:0] output_data;

  modport master (
    input  start, acc_data,
    output finish, busy, pixel_req, pixel_addr, weight_req, weight_addr,
           mac_en, mac_clr, output_req, output_addr, output_data
  );

  modport slave (
    output start, acc_data,
    input  finish, busy, pixel_req, pixel_addr, weight_req, weight_addr,
           mac_en, mac_clr, output_req, output_addr, output_data
  );

endinterface
`default_nettype wire

// File: rtl/conv_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_addr_gen                                                |
// | Description : Output (ox,oy) and tap (kx,ky) counters with incremental     |
// |               row-base registers; produces pixel, weight and output        |
// |               addresses without any runtime multiplier.                    |
// | Ports       : clk, reset (async active-low)                                |
// |               i_clr      - zero all counters (start of a pass)             |
// |               i_tap_step - advance to the next kernel tap                  |
// |               i_out_step - advance to the next output pixel                |
// |               o_pixel_addr / o_weight_addr / o_output_addr                 |
// |               o_first_tap, o_last_tap, o_last_out                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv_addr_gen #(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int K        = 3,
  parameter int PIX_AW   = 10,
  parameter int WGT_AW   = 10,
  parameter int OUT_AW   = 10,
  parameter int WGT_BASE = 0,
  parameter int OUT_BASE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clr,
  input  logic              i_tap_step,
  input  logic              i_out_step,
  output logic [PIX_AW-1:0] o_pixel_addr,
  output logic [WGT_AW-1:0] o_weight_addr,
  output logic [OUT_AW-1:0] o_output_addr,
  output logic              o_first_tap,
  output logic              o_last_tap,
  output logic              o_last_out
);

  localparam int c_OUT_W = IMG_W - K + 1;
  localparam int c_OUT_H = IMG_H - K + 1;
  localparam int c_CW    = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);

  localparam logic [c_CW-1:0]   c_ONE      = c_CW'(1);
  localparam logic [c_CW-1:0]   c_KM1      = c_CW'(K - 1);
  localparam logic [c_CW-1:0]   c_OXM      = c_CW'(c_OUT_W - 1);
  localparam logic [c_CW-1:0]   c_OYM      = c_CW'(c_OUT_H - 1);
  localparam logic [PIX_AW-1:0] c_ROW_STEP = PIX_AW'(IMG_W);
  localparam logic [WGT_AW-1:0] c_WGT_STEP = WGT_AW'(K);
  localparam logic [WGT_AW-1:0] c_WGT_BASE = WGT_AW'(WGT_BASE);
  localparam logic [OUT_AW-1:0] c_OUT_STEP = OUT_AW'(c_OUT_W);
  localparam logic [OUT_AW-1:0] c_OUT_BASE = OUT_AW'(OUT_BASE);

  logic [c_CW-1:0]   r_ox, r_oy, r_kx, r_ky;
  logic [PIX_AW-1:0] r_out_row;   // oy * IMG_W
  logic [PIX_AW-1:0] r_tap_row;   // (oy + ky) * IMG_W
  logic [WGT_AW-1:0] r_wgt_row;   // ky * K
  logic [OUT_AW-1:0] r_out_ybase; // oy * OUT_W

  assign o_first_tap = (r_kx == '0)    && (r_ky == '0);
  assign o_last_tap  = (r_kx == c_KM1) && (r_ky == c_KM1);
  assign o_last_out  = (r_ox == c_OXM) && (r_oy == c_OYM);

  assign o_pixel_addr  = r_tap_row + PIX_AW'(r_ox) + PIX_AW'(r_kx);
  assign o_weight_addr = c_WGT_BASE + r_wgt_row + WGT_AW'(r_kx);
  assign o_output_addr = c_OUT_BASE + r_out_ybase + OUT_AW'(r_ox);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ox        <= '0;
      r_oy        <= '0;
      r_kx        <= '0;
      r_ky        <= '0;
      r_out_row   <= '0;
      r_tap_row   <= '0;
      r_wgt_row   <= '0;
      r_out_ybase <= '0;
    end else if (i_clr) begin
      r_ox        <= '0;
      r_oy        <= '0;
      r_kx        <= '0;
      r_ky        <= '0;
      r_out_row   <= '0;
      r_tap_row   <= '0;
      r_wgt_row   <= '0;
      r_out_ybase <= '0;
    end else if (i_tap_step) begin
      if (r_kx == c_KM1) begin
        r_kx <= '0;
        if (r_ky == c_KM1) begin
          // Kernel finished: rewind the tap row so the next output pixel
          // starts at its own top-left corner.
          r_ky      <= '0;
          r_tap_row <= r_out_row;
          r_wgt_row <= '0;
        end else begin
          r_ky      <= r_ky + c_ONE;
          r_tap_row <= r_tap_row + c_ROW_STEP;
          r_wgt_row <= r_wgt_row + c_WGT_STEP;
        end
      end else begin
        r_kx <= r_kx + c_ONE;
      end
    end else if (i_out_step && !o_last_out) begin
      // The final output does not advance, so no register ever steps past
      // the last legal row and nothing can wrap.
      if (r_ox == c_OXM) begin
        r_ox        <= '0;
        r_oy        <= r_oy + c_ONE;
        r_out_row   <= r_out_row + c_ROW_STEP;
        r_tap_row   <= r_out_row + c_ROW_STEP;
        r_out_ybase <= r_out_ybase + c_OUT_STEP;
      end else begin
        r_ox <= r_ox + c_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : conv_sequencer                                               |
// | Description : Control FSM for one single-channel KxK convolution pass.     |
// |               Per output pixel: K*K fetch cycles (pixel+weight reads),     |
// |               one drain cycle for the last MAC, one output write cycle.    |
// | Ports       : clk   - clock, rising edge                                   |
// |               reset - asynchronous active-low reset                        |
// |               bus   - conv_sequencer_if.master (start/finish/busy, SRAM    |
// |                       read/write ports, MAC strobes, accumulator input)    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module conv_sequencer
  import conv_pkg::*;
#(
  parameter int IMG_W    = 32,
  parameter int IMG_H    = 32,
  parameter int K        = 3,
  parameter int PIX_AW   = c_ADDR_W,
  parameter int WGT_AW   = c_ADDR_W,
  parameter int OUT_AW   = c_ADDR_W,
  parameter int OUT_DW   = c_OUT_DW,
  parameter int WGT_BASE = 0,
  parameter int OUT_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  conv_sequencer_if.master bus
);

  localparam int c_OUT_W = IMG_W - K + 1;
  localparam int c_OUT_H = IMG_H - K + 1;
  localparam int c_N     = c_OUT_W * c_OUT_H;

  generate
    if (K < 1 || K > IMG_W || K > IMG_H) begin : g_chk_kernel
      $fatal(1, "conv_sequencer: kernel does not fit in the image");
    end
    if (longint'(IMG_W) * longint'(IMG_H) > (longint'(1) << PIX_AW)) begin : g_chk_pix
      $fatal(1, "conv_sequencer: image exceeds pixel address space");
    end
    if (longint'(WGT_BASE) + longint'(K) * longint'(K) > (longint'(1) << WGT_AW)) begin : g_chk_wgt
      $fatal(1, "conv_sequencer: kernel exceeds weight address space");
    end
    if (longint'(OUT_BASE) + longint'(c_N) > (longint'(1) << OUT_AW)) begin : g_chk_out
      $fatal(1, "conv_sequencer: output map exceeds output address space");
    end
  endgenerate

  state_t r_state, w_next;
  logic   r_mac_en, r_mac_clr;

  logic w_pixel_req, w_output_req, w_finish;
  logic w_clr, w_tap_step, w_out_step;
  logic w_first_tap, w_last_tap, w_last_out;

  logic [PIX_AW-1:0] w_pix_addr;
  logic [WGT_AW-1:0] w_wgt_addr;
  logic [OUT_AW-1:0] w_out_addr;
  logic [OUT_DW-1:0] w_acc;

  conv_addr_gen #(
    .IMG_W    (IMG_W),
    .IMG_H    (IMG_H),
    .K        (K),
    .PIX_AW   (PIX_AW),
    .WGT_AW   (WGT_AW),
    .OUT_AW   (OUT_AW),
    .WGT_BASE (WGT_BASE),
    .OUT_BASE (OUT_BASE)
  ) u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .i_clr         (w_clr),
    .i_tap_step    (w_tap_step),
    .i_out_step    (w_out_step),
    .o_pixel_addr  (w_pix_addr),
    .o_weight_addr (w_wgt_addr),
    .o_output_addr (w_out_addr),
    .o_first_tap   (w_first_tap),
    .o_last_tap    (w_last_tap),
    .o_last_out    (w_last_out)
  );

  // The MAC strobes trail the read request by one cycle so they line up with
  // the SRAM read data; mac_clr marks the first tap of each output pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_mac_en  <= 1'b0;
      r_mac_clr <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_mac_en  <= w_pixel_req;
      r_mac_clr <= w_pixel_req & w_first_tap;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_pixel_req  = 1'b0;
    w_output_req = 1'b0;
    w_finish     = 1'b0;
    w_clr        = 1'b0;
    w_tap_step   = 1'b0;
    w_out_step   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_clr  = 1'b1;
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_pixel_req = 1'b1;
        w_tap_step  = 1'b1;
        if (w_last_tap) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_next = ST_WRITE;
      end
      ST_WRITE: begin
        w_output_req = 1'b1;
        w_out_step   = 1'b1;
        w_next       = w_last_out ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        w_finish = 1'b1;
        w_next   = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Addresses are forced to zero whenever their strobe is low so an idle or
  // reset sequencer presents an all-zero bus.
  assign w_acc           = bus.acc_data;
  assign bus.output_data = w_acc;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.finish      = w_finish;
  assign bus.pixel_req   = w_pixel_req;
  assign bus.pixel_addr  = w_pixel_req ? w_pix_addr : '0;
  assign bus.weight_req  = w_pixel_req;
  assign bus.weight_addr = w_pixel_req ? w_wgt_addr : '0;
  assign bus.mac_en      = r_mac_en;
  assign bus.mac_clr     = r_mac_clr;
  assign bus.output_req  = w_output_req;
  assign bus.output_addr = w_output_req ? w_out_addr : '0;

endmodule
`default_nettype wire

// File: tb/tb_conv_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_conv_sequencer                                            |
// | Description : Directed bench for conv_sequencer: a 4x4/K=3 instance with   |
// |               a pixel/weight SRAM and MAC model, plus a default 32x32      |
// |               instance for the full-size pass.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_conv_sequencer;
  import conv_pkg::*;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  int   pix_mode;

  conv_sequencer_if bs ();
  conv_sequencer_if bb ();

  conv_sequencer #(.IMG_W(4), .IMG_H(4), .K(3)) u_small (
    .clk   (clk),
    .reset (reset),
    .bus   (bs)
  );

  conv_sequencer u_big (
    .clk   (clk),
    .reset (reset),
    .bus   (bb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---- SRAM + MAC model for the small instance ----
  logic [c_PIX_DW-1:0] s_pix_d;
  logic [c_WGT_DW-1:0] s_wgt_d;
  logic [c_OUT_DW-1:0] s_acc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_pix_d <= '0;
      s_wgt_d <= '0;
      s_acc   <= '0;
    end else begin
      if (bs.pixel_req)
        s_pix_d <= (pix_mode != 0) ? c_PIX_DW'(bs.pixel_addr + 10'd1) : c_PIX_DW'(1);
      if (bs.weight_req)
        s_wgt_d <= c_WGT_DW'(1);
      if (bs.mac_en)
        s_acc <= (bs.mac_clr ? '0 : s_acc) + (c_OUT_DW'(s_pix_d) * c_OUT_DW'(s_wgt_d));
    end
  end

  assign bs.acc_data = s_acc;
  assign bb.acc_data = '0;

  // ---- small-instance monitor ----
  int s_pix_q[$], s_wgt_q[$], s_clr_idx[$], s_oaddr_q[$], s_odata_q[$], s_fin_q[$];
  int s_first_req, s_last_pix, s_mac_cnt, s_clr_orphan, s_idle_between, s_busy_cnt, s_rst_act;

  always @(negedge clk) begin
    if (bs.pixel_req) begin
      if (s_first_req < 0) s_first_req = cyc;
      s_pix_q.push_back(int'(bs.pixel_addr));
      s_last_pix = int'(bs.pixel_addr);
    end
    if (bs.weight_req) s_wgt_q.push_back(int'(bs.weight_addr));
    if (bs.mac_en) begin
      if (bs.mac_clr) s_clr_idx.push_back(s_mac_cnt);
      s_mac_cnt = s_mac_cnt + 1;
    end
    if (bs.mac_clr && !bs.mac_en) s_clr_orphan = s_clr_orphan + 1;
    if (bs.output_req) begin
      s_oaddr_q.push_back(int'(bs.output_addr));
      s_odata_q.push_back(int'(bs.output_data));
    end
    if (bs.finish) s_fin_q.push_back(cyc);
    if (bs.busy) s_busy_cnt = s_busy_cnt + 1;
    if (!bs.busy && s_fin_q.size() == 1 && s_pix_q.size() > 0)
      s_idle_between = s_idle_between + 1;
    if (!reset && (bs.pixel_req || bs.weight_req || bs.mac_en || bs.mac_clr ||
                   bs.output_req || bs.finish || bs.busy))
      s_rst_act = s_rst_act + 1;
  end

  // ---- big-instance monitor ----
  int b_first_req, b_last_pix, b_pix_cnt, b_out_cnt, b_order_err, b_fin_cyc, b_fin_cnt;

  always @(negedge clk) begin
    if (bb.pixel_req) begin
      if (b_first_req < 0) b_first_req = cyc;
      b_last_pix = int'(bb.pixel_addr);
      b_pix_cnt  = b_pix_cnt + 1;
    end
    if (bb.output_req) begin
      if (int'(bb.output_addr) != b_out_cnt) b_order_err = b_order_err + 1;
      b_out_cnt = b_out_cnt + 1;
    end
    if (bb.finish) begin
      b_fin_cyc = cyc;
      b_fin_cnt = b_fin_cnt + 1;
    end
  end

  // ---- helpers ----
  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    s_pix_q.delete();
    s_wgt_q.delete();
    s_clr_idx.delete();
    s_oaddr_q.delete();
    s_odata_q.delete();
    s_fin_q.delete();
    s_first_req    = -1;
    s_last_pix     = -1;
    s_mac_cnt      = 0;
    s_clr_orphan   = 0;
    s_idle_between = 0;
    s_busy_cnt     = 0;
    s_rst_act      = 0;
  endtask

  // Leaves the caller at negedge+1 of the first FETCH cycle.
  task automatic start_pass_s();
    @(negedge clk); #1;
    bs.start = 1'b1;
    @(negedge clk); #1;
    bs.start = 1'b0;
  endtask

  task automatic wait_fin_s(input int n, input int limit, input string tag);
    int k;
    k = 0;
    while (s_fin_q.size() < n && k < limit) begin
      @(negedge clk); #1;
      k++;
    end
    check({tag, " finish_seen"}, longint'(s_fin_q.size() >= n), 1);
  endtask

  // Full expectation set for one clean 4x4/K=3 pass, from the window formula.
  task automatic check_clean_pass(input string tag, input int d0, input int d1,
                                  input int d2, input int d3);
    int dexp[4];
    int idx, perr, werr, cerr, aerr, derr;
    dexp = '{d0, d1, d2, d3};
    idx = 0; perr = 0; werr = 0; cerr = 0; aerr = 0; derr = 0;
    for (int oy = 0; oy < 2; oy++)
      for (int ox = 0; ox < 2; ox++)
        for (int ky = 0; ky < 3; ky++)
          for (int kx = 0; kx < 3; kx++) begin
            if (idx >= s_pix_q.size() || s_pix_q[idx] != (oy + ky) * 4 + ox + kx) perr++;
            if (idx >= s_wgt_q.size() || s_wgt_q[idx] != ky * 3 + kx) werr++;
            idx++;
          end
    for (int i = 0; i < 4; i++) begin
      if (i >= s_clr_idx.size() || s_clr_idx[i] != 9 * i) cerr++;
      if (i >= s_oaddr_q.size() || s_oaddr_q[i] != i) aerr++;
      if (i >= s_odata_q.size() || s_odata_q[i] != dexp[i]) derr++;
    end
    check({tag, " pix_cnt"}, s_pix_q.size(), 36);
    check({tag, " pix_seq_err"}, perr, 0);
    check({tag, " wgt_seq_err"}, werr, 0);
    check({tag, " last_pix"}, s_last_pix, 15);
    check({tag, " mac_cnt"}, s_mac_cnt, 36);
    check({tag, " clr_cnt"}, s_clr_idx.size(), 4);
    check({tag, " clr_pos_err"}, cerr, 0);
    check({tag, " clr_orphan"}, s_clr_orphan, 0);
    check({tag, " out_cnt"}, s_oaddr_q.size(), 4);
    check({tag, " out_addr_err"}, aerr, 0);
    check({tag, " out_data_err"}, derr, 0);
    check({tag, " fin_cnt"}, s_fin_q.size(), 1);
    check({tag, " fin_latency"}, s_fin_q[0] - s_first_req, 44);
  endtask

  // ---- directed sequence ----
  initial begin
    int k;
    total    = 0;
    bad      = 0;
    pix_mode = 0;
    b_first_req = -1; b_last_pix = -1; b_pix_cnt = 0; b_out_cnt = 0;
    b_order_err = 0;  b_fin_cyc = 0;   b_fin_cnt = 0;
    clear_logs();
    reset    = 1'b1;
    bs.start = 1'b1;
    bb.start = 1'b1;
    #1 reset = 1'b0;

    // Reset held with start high: everything quiet.
    repeat (3) @(negedge clk);
    #1;
    check("rst small ctrl", {bs.finish, bs.busy, bs.pixel_req, bs.weight_req,
                             bs.mac_en, bs.mac_clr, bs.output_req}, 0);
    check("rst small addr", {bs.pixel_addr, bs.weight_addr, bs.output_addr}, 0);
    check("rst big ctrl", {bb.finish, bb.busy, bb.pixel_req, bb.weight_req,
                           bb.mac_en, bb.mac_clr, bb.output_req}, 0);
    bs.start = 1'b0;
    bb.start = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    clear_logs();
    repeat (20) @(negedge clk);
    #1;
    check("idle req_cnt", s_pix_q.size(), 0);
    check("idle busy_cnt", s_busy_cnt, 0);
    check("idle out_cnt", s_oaddr_q.size(), 0);

    // Clean 4x4 pass, all-ones data.
    clear_logs();
    start_pass_s();
    wait_fin_s(1, 200, "p1");
    @(negedge clk); #1;
    check("p1 finish_width", bs.finish, 0);
    check("p1 busy_after_done", bs.busy, 0);
    repeat (3) @(negedge clk);
    #1;
    check_clean_pass("p1", 9, 9, 9, 9);

    // Pixel value = address + 1: window sums 9*base + 54.
    pix_mode = 1;
    clear_logs();
    start_pass_s();
    wait_fin_s(1, 200, "p2");
    repeat (4) @(negedge clk);
    #1;
    check_clean_pass("p2", 54, 63, 90, 99);
    pix_mode = 0;

    // start pulses at cycles 5 and 30 of a running pass are ignored.
    clear_logs();
    start_pass_s();
    repeat (5) @(negedge clk);
    #1 bs.start = 1'b1;
    @(negedge clk); #1 bs.start = 1'b0;
    repeat (24) @(negedge clk);
    #1 bs.start = 1'b1;
    @(negedge clk); #1 bs.start = 1'b0;
    wait_fin_s(1, 200, "p3");
    repeat (10) @(negedge clk);
    #1;
    check_clean_pass("p3", 9, 9, 9, 9);

    // Asynchronous reset during the second output's FETCH.
    clear_logs();
    start_pass_s();
    repeat (14) @(negedge clk);
    #1;
    check("p4 req_before_rst", bs.pixel_req, 1);
    reset = 1'b0;
    #1;
    check("p4 rst ctrl_now", {bs.finish, bs.busy, bs.pixel_req, bs.weight_req,
                              bs.mac_en, bs.mac_clr, bs.output_req}, 0);
    check("p4 rst addr_now", {bs.pixel_addr, bs.weight_addr, bs.output_addr}, 0);
    repeat (5) @(negedge clk);
    #1;
    check("p4 no_finish", s_fin_q.size(), 0);
    check("p4 out_cnt", s_oaddr_q.size(), 1);
    check("p4 rst_activity", s_rst_act, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    clear_logs();
    start_pass_s();
    wait_fin_s(1, 200, "p5");
    repeat (3) @(negedge clk);
    #1;
    check_clean_pass("p5", 9, 9, 9, 9);

    // start held high: two back-to-back passes.
    clear_logs();
    @(negedge clk); #1;
    bs.start = 1'b1;
    wait_fin_s(2, 300, "p6");
    bs.start = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    k = 0;
    for (int i = 0; i < 8; i++)
      if (i >= s_oaddr_q.size() || s_oaddr_q[i] != (i % 4) || s_odata_q[i] != 9) k++;
    check("p6 fin_cnt", s_fin_q.size(), 2);
    check("p6 fin_spacing", s_fin_q[1] - s_fin_q[0], 46);
    check("p6 idle_between", s_idle_between, 1);
    check("p6 out_cnt", s_oaddr_q.size(), 8);
    check("p6 out_err", k, 0);
    check("p6 pix_cnt", s_pix_q.size(), 72);

    // Default 32x32, K=3.
    @(negedge clk); #1;
    bb.start = 1'b1;
    @(negedge clk); #1;
    bb.start = 1'b0;
    k = 0;
    while (b_fin_cnt < 1 && k < 12000) begin
      @(negedge clk); #1;
      k++;
    end
    check("big finish_seen", longint'(b_fin_cnt >= 1), 1);
    repeat (5) @(negedge clk);
    #1;
    check("big fin_cnt", b_fin_cnt, 1);
    check("big out_cnt", b_out_cnt, 900);
    check("big out_order_err", b_order_err, 0);
    check("big pix_cnt", b_pix_cnt, 8100);
    check("big last_pix", b_last_pix, 1023);
    check("big fin_latency", b_fin_cyc - b_first_req, 9900);
    check("big busy_after", bb.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
- Control FSM that sequences one single-channel KxK convolution pass over an IMG_W x IMG_H image.
- For each output pixel, issues pixel and weight SRAM read requests, drives accumulate strobes to the conv MAC datapath, and writes the accumulated result to the output SRAM.
- Sits between the top-level start/finish handshake and the three SRAM ports; owns all address generation.

Parameters:
- IMG_W, 32, image width in pixels
- IMG_H, 32, image height in pixels
- K, 3, kernel side length (K*K taps)
- PIX_AW, 10, pixel SRAM address width
- WGT_AW, 10, weight SRAM address width
- OUT_AW, 10, output SRAM address width
- OUT_DW, 20, output data width
- WGT_BASE, 0, weight SRAM address of tap (0,0)
- OUT_BASE, 0, output SRAM address of output (0,0)

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level; sampled only in IDLE
- finish  out  1  one-cycle pulse when the pass completes
- busy  out  1  high in every state except IDLE
- pixel_req  out  1  pixel SRAM read enable; data valid the next cycle
- pixel_addr  out  PIX_AW  pixel read address
- weight_req  out  1  weight SRAM read enable; data valid the next cycle
- weight_addr  out  WGT_AW  weight read address
- mac_en  out  1  datapath accumulates the current pixel*weight
- mac_clr  out  1  with mac_en: acc <= product (discards the old accumulator)
- acc_data  in  OUT_DW  datapath accumulator value
- output_req  out  1  output SRAM write enable
- output_addr  out  OUT_AW  output write address
- output_data  out  OUT_DW  write data; equals acc_data combinationally

Behaviour:
- Definitions: OUT_W = IMG_W-K+1, OUT_H = IMG_H-K+1, N = OUT_W*OUT_H.
- Reset (reset low, asynchronous): FSM goes to IDLE. All outputs are 0, all counters are 0.
- States: IDLE, FETCH, DRAIN, WRITE, DONE.
- IDLE: if start=1 at a rising edge, go to FETCH with ox=oy=kx=ky=0. Otherwise stay.
- FETCH, one tap per cycle:
  - pixel_req=weight_req=1.
  - pixel_addr = (oy+ky)*IMG_W + (ox+kx).
  - weight_addr = WGT_BASE + ky*K + kx.
  - kx increments; on wrap kx=0 and ky++.
  - After tap (K-1,K-1), go to DRAIN.
- mac_en is pixel_req delayed one cycle, so it is aligned with SRAM data. It is high in FETCH cycles 2..K*K and in DRAIN. mac_clr is high only together with the first mac_en of each output pixel.
- DRAIN: reqs low, last mac_en. Next state is WRITE.
- WRITE:
  - output_req=1, output_addr = OUT_BASE + oy*OUT_W + ox, output_data = acc_data.
  - ox++; on wrap ox=0 and oy++.
  - After output (OUT_W-1,OUT_H-1), go to DONE; else go to FETCH with kx=ky=0.
- DONE: finish=1 for exactly one cycle, then IDLE. busy=0 in the DONE->IDLE cycle.
- Latency: K*K+2 cycles per output. finish is asserted N*(K*K+2) cycles after the first pixel_req cycle.
- start while busy: ignored, no restart. start held high through DONE: a new pass begins from the IDLE cycle after DONE.
- Address generation uses incremental row-base registers; no runtime multipliers. Address registers are sized so no intermediate wraps for legal parameters.
- Elaboration-time checks: IMG_W*IMG_H <= 2^PIX_AW, WGT_BASE+K*K <= 2^WGT_AW, OUT_BASE+N <= 2^OUT_AW, K <= IMG_W and K <= IMG_H. A violation is a fatal error.
- Reset mid-operation: aborts immediately. No further req, mac_en or output_req. finish is not pulsed.
- No write-back of partial results; every output is written exactly once per pass.

Decomposition:
- Shared package conv_pkg: state encoding enum (IDLE/FETCH/DRAIN/WRITE/DONE), default width constants (pixel 9, weight 8, address 10, output 20).
- One natural sub-module, conv_addr_gen: holds the ox/oy/kx/ky counters and row-base registers, and produces the three addresses plus last-tap and last-output flags.
- The FSM and strobe alignment stay in conv_sequencer.

Test Plan:
- Reset check: hold reset low with start=1 -> all outputs 0, busy=0. Release reset with start=0 -> stays IDLE, no req for 20 cycles.
- IMG 4x4, K=3, single pass:
  - First output pixel_addr sequence is 0,1,2,4,5,6,8,9,10; weight_addr is 0..8.
  - mac_clr coincides with the first mac_en only.
  - output_req at addresses 0,1,2,3.
  - finish pulses exactly 44 cycles after the first pixel_req.
  - With the datapath model fed all-ones pixels and weights, output_data = 9 each.
- Default 32x32, K=3:
  - Exactly 900 output_req pulses with addresses 0..899 in order.
  - Last pixel_addr = 1023.
  - finish 9900 cycles after the first pixel_req.
- start pulsed at cycles 5 and 30 of a running 4x4 pass -> the sequence is identical to a clean run, and there is exactly one finish.
- reset asserted during the second output's FETCH -> outputs go to 0 immediately, no finish. A new start then produces a full clean 4x4 pass from pixel_addr 0.
- start held high continuously -> two back-to-back 4x4 passes, with two finish pulses 46 cycles apart and one IDLE cycle between them.
